// File: rtl/display_scan_ctrl.sv
// Eight-digit seven-segment scan controller with frame-synchronous double buffering.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shows).
module display_scan_ctrl #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int DIGIT_HZ     = 800,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] value,
  input  logic        load,
  input  logic [7:0]  dp_mask,
  output logic [2:0]  cuenta,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        frame_tick
);

  localparam int DIV = CLK_HZ / DIGIT_HZ;
  localparam int PW  = $clog2(DIV);
  localparam int BW  = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
  localparam logic [BW-1:0] B_INIT = BW'(BLANK_CYCLES);

  logic [PW-1:0] r_pcnt;
  logic [2:0]    r_cuenta;
  logic [31:0]   r_shadow;
  logic [7:0]    r_shadow_dp;
  logic [31:0]   r_pend_val;
  logic [7:0]    r_pend_dp;
  logic          r_pend_flag;
  logic [BW-1:0] r_blank;
  logic [6:0]    r_seg_n;
  logic          r_dp_n;
  logic          r_frame_tick;

  logic          w_tick;
  logic          w_wrap;
  logic [PW-1:0] w_pcnt_next;
  logic [2:0]    w_cuenta_next;
  logic [BW-1:0] w_blank_next;
  logic [31:0]   w_shadow_next;
  logic [7:0]    w_shadow_dp_next;
  logic [31:0]   w_pend_val_next;
  logic [7:0]    w_pend_dp_next;
  logic          w_pend_flag_next;
  logic [3:0]    w_nib;
  logic          w_blank_on;
  logic          w_lz_on;
  logic [6:0]    w_seg_next;
  logic          w_dp_next;

  function automatic logic [6:0] hex7seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_comb begin
    w_tick        = (r_pcnt == P_LAST);
    w_wrap        = w_tick && (r_cuenta == 3'd7);
    w_pcnt_next   = w_tick ? '0 : r_pcnt + PW'(1);
    w_cuenta_next = w_tick ? r_cuenta + 3'd1 : r_cuenta;

    if (w_tick)
      w_blank_next = B_INIT;
    else if (r_blank != '0)
      w_blank_next = r_blank - BW'(1);
    else
      w_blank_next = r_blank;

    w_shadow_next    = r_shadow;
    w_shadow_dp_next = r_shadow_dp;
    w_pend_val_next  = r_pend_val;
    w_pend_dp_next   = r_pend_dp;
    w_pend_flag_next = r_pend_flag;

    if (load) begin
      w_pend_val_next  = value;
      w_pend_dp_next   = dp_mask;
      w_pend_flag_next = 1'b1;
    end

    // A load landing exactly on the wrap bypasses the pending stage.
    if (w_wrap) begin
      if (load) begin
        w_shadow_next    = value;
        w_shadow_dp_next = dp_mask;
        w_pend_flag_next = 1'b0;
      end else if (r_pend_flag) begin
        w_shadow_next    = r_pend_val;
        w_shadow_dp_next = r_pend_dp;
        w_pend_flag_next = 1'b0;
      end
    end

    w_nib      = w_shadow_next[{w_cuenta_next, 2'b00} +: 4];
    w_blank_on = (w_blank_next != '0);
    w_seg_next = (w_blank_on || w_lz_on) ? 7'h7F : hex7seg(w_nib);
    w_dp_next  = w_blank_on | ~w_shadow_dp_next[w_cuenta_next];
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [7:0] w_lz;
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lz
      if (gi == 0) begin : g_first
        assign w_lz[gi] = 1'b0;
      end else begin : g_upper
        assign w_lz[gi] = (w_shadow_next[31:4*gi] == '0);
      end
    end
  endgenerate
  assign w_lz_on = w_lz[w_cuenta_next];
`else
  assign w_lz_on = 1'b0;
`endif

  // Outputs are computed from next-state values so they line up with the new cuenta.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pcnt       <= '0;
      r_cuenta     <= 3'd0;
      r_shadow     <= 32'd0;
      r_shadow_dp  <= 8'd0;
      r_pend_val   <= 32'd0;
      r_pend_dp    <= 8'd0;
      r_pend_flag  <= 1'b0;
      r_blank      <= B_INIT;
      r_seg_n      <= 7'h7F;
      r_dp_n       <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_pcnt       <= w_pcnt_next;
      r_cuenta     <= w_cuenta_next;
      r_shadow     <= w_shadow_next;
      r_shadow_dp  <= w_shadow_dp_next;
      r_pend_val   <= w_pend_val_next;
      r_pend_dp    <= w_pend_dp_next;
      r_pend_flag  <= w_pend_flag_next;
      r_blank      <= w_blank_next;
      r_seg_n      <= w_seg_next;
      r_dp_n       <= w_dp_next;
      r_frame_tick <= w_wrap;
    end
  end

  assign cuenta     = r_cuenta;
  assign seg_n      = r_seg_n;
  assign dp_n       = r_dp_n;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: frame-level reference model, vector table and directed corner sequences.
// Honours LEADING_ZERO_BLANK_EN the same way as the design.
module tb_display_scan_ctrl;
  localparam int B = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] value = 32'd0;
  logic        load = 1'b0;
  logic [7:0]  dp_mask = 8'd0;
  logic [2:0]  cuenta;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        frame_tick;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  display_scan_ctrl #(.CLK_HZ(800), .DIGIT_HZ(100), .BLANK_CYCLES(B)) dut (
    .clk(clk), .reset_n(reset_n), .value(value), .load(load), .dp_mask(dp_mask),
    .cuenta(cuenta), .seg_n(seg_n), .dp_n(dp_n), .frame_tick(frame_tick)
  );

  logic [6:0] hex_tab [16];

  // Reference model: a frame is 64 cycles; the shown word is the latest load made before the frame began.
  int          n;
  logic [31:0] m_shadow, m_pend_val;
  logic [7:0]  m_shadow_dp, m_pend_dp;
  bit          m_pend;

  typedef struct {
    logic [31:0] val;
    logic [7:0]  dp;
    int          digit;
    logic [6:0]  exp_seg;
    logic        exp_dp;
  } vec_t;
  vec_t tab [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at n=%0d: got %h, expected %h", name, n, act, exp);
    end
  endtask

  task automatic model_reset();
    n = 0;
    m_shadow = 32'd0;
    m_shadow_dp = 8'd0;
    m_pend = 1'b0;
  endtask

  // Checks the current cycle against the model, applies this cycle's inputs, advances one clock.
  task automatic cycle(input bit do_load, input logic [31:0] v, input logic [7:0] d);
    int dig;
    bit blank;
    logic [6:0] eseg;
    logic edp;
    if (n > 0 && n % 64 == 0 && m_pend) begin
      m_shadow = m_pend_val;
      m_shadow_dp = m_pend_dp;
      m_pend = 1'b0;
    end
    dig = (n / 8) % 8;
    blank = (n % 8) < B;
    eseg = hex_tab[(m_shadow >> (4 * dig)) & 32'hF];
`ifdef LEADING_ZERO_BLANK_EN
    if (dig > 0 && (m_shadow >> (4 * dig)) == 0) eseg = 7'h7F;
`endif
    if (blank) eseg = 7'h7F;
    edp = blank ? 1'b1 : ~m_shadow_dp[dig];
    check("cuenta", 32'(cuenta), 32'(dig));
    check("seg_n", 32'(seg_n), 32'(eseg));
    check("dp_n", 32'(dp_n), 32'(edp));
    check("frame_tick", 32'(frame_tick), 32'(n > 0 && n % 64 == 0));
    load = do_load;
    value = v;
    dp_mask = d;
    if (do_load) begin
      m_pend_val = v;
      m_pend_dp = d;
      m_pend = 1'b1;
    end
    @(posedge clk);
    #1;
    n++;
    load = 1'b0;
  endtask

  task automatic idle_until(input int pos);
    while (n % 64 != pos) cycle(1'b0, 32'd0, 8'd0);
  endtask

  initial begin
    hex_tab[0] = 7'b1000000;  hex_tab[1] = 7'b1111001;  hex_tab[2] = 7'b0100100;  hex_tab[3] = 7'b0110000;
    hex_tab[4] = 7'b0011001;  hex_tab[5] = 7'b0010010;  hex_tab[6] = 7'b0000010;  hex_tab[7] = 7'b1111000;
    hex_tab[8] = 7'b0000000;  hex_tab[9] = 7'b0010000;  hex_tab[10] = 7'b0001000; hex_tab[11] = 7'b0000011;
    hex_tab[12] = 7'b1000110; hex_tab[13] = 7'b0100001; hex_tab[14] = 7'b0000110; hex_tab[15] = 7'b0001110;

    tab[0]  = '{32'h00000000, 8'h00, 0, 7'b1000000, 1'b1};
    tab[1]  = '{32'h11111111, 8'h02, 1, 7'b1111001, 1'b0};
    tab[2]  = '{32'h22222222, 8'h00, 2, 7'b0100100, 1'b1};
    tab[3]  = '{32'h33333333, 8'h08, 3, 7'b0110000, 1'b0};
    tab[4]  = '{32'h44444444, 8'h00, 4, 7'b0011001, 1'b1};
    tab[5]  = '{32'h55555555, 8'h20, 5, 7'b0010010, 1'b0};
    tab[6]  = '{32'h66666666, 8'h00, 6, 7'b0000010, 1'b1};
    tab[7]  = '{32'h77777777, 8'h80, 7, 7'b1111000, 1'b0};
    tab[8]  = '{32'h88888888, 8'h00, 0, 7'b0000000, 1'b1};
    tab[9]  = '{32'h99999999, 8'h02, 1, 7'b0010000, 1'b0};
    tab[10] = '{32'hAAAAAAAA, 8'h00, 2, 7'b0001000, 1'b1};
    tab[11] = '{32'hBBBBBBBB, 8'h08, 3, 7'b0000011, 1'b0};
    tab[12] = '{32'hCCCCCCCC, 8'h00, 4, 7'b1000110, 1'b1};
    tab[13] = '{32'hDDDDDDDD, 8'h20, 5, 7'b0100001, 1'b0};
    tab[14] = '{32'hEEEEEEEE, 8'h00, 6, 7'b0000110, 1'b1};
    tab[15] = '{32'hFFFFFFFF, 8'h80, 7, 7'b0001110, 1'b0};
    tab[16] = '{32'h89ABCDEF, 8'h00, 0, 7'b0001110, 1'b1};
    tab[17] = '{32'h89ABCDEF, 8'h00, 7, 7'b0000000, 1'b1};
    tab[18] = '{32'h89ABCDEF, 8'h00, 3, 7'b1000110, 1'b1};
    tab[19] = '{32'h00000000, 8'h04, 2, 7'b1000000, 1'b0};

    n = 0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();

    // Free run after reset: display shows 0, frame_tick every 64 cycles.
    repeat (200) cycle(1'b0, 32'd0, 8'd0);
    $display("reset run: 200 cycles checked");

    // Vector table: load mid-frame, check the chosen digit in the next frame once unblanked.
    for (int i = 0; i < 20; i++) begin
      idle_until(20);
      cycle(1'b1, tab[i].val, tab[i].dp);
      idle_until(0);
      idle_until(8 * tab[i].digit + B);
      check($sformatf("tab%0d_seg", i), 32'(seg_n), 32'(tab[i].exp_seg));
      check($sformatf("tab%0d_dp", i), 32'(dp_n), 32'(tab[i].exp_dp));
      $display("vector %0d: value=%h dp=%h digit=%0d seg_n=%b dp_n=%b", i, tab[i].val, tab[i].dp,
               tab[i].digit, seg_n, dp_n);
    end

    // Two loads in one frame: only the later one reaches the display.
    idle_until(10);
    cycle(1'b1, 32'h12345678, 8'h00);
    idle_until(30);
    cycle(1'b1, 32'h000000A5, 8'h00);
    idle_until(0);
    idle_until(B);
    check("two_loads_d0", 32'(seg_n), 32'(7'b0010010));
    idle_until(8 + B);
    check("two_loads_d1", 32'(seg_n), 32'(7'b0001000));
    idle_until(16 + B);
`ifdef LEADING_ZERO_BLANK_EN
    check("two_loads_d2", 32'(seg_n), 32'(7'h7F));
`else
    check("two_loads_d2", 32'(seg_n), 32'(7'b1000000));
`endif
    $display("double load: d2 seg_n=%b", seg_n);

    // Load in the exact wrap cycle lands in the very next frame.
    idle_until(63);
    cycle(1'b1, 32'h11111111, 8'h00);
    check("wrap_load_cuenta", 32'(cuenta), 32'd0);
    idle_until(B);
    check("wrap_load_d0", 32'(seg_n), 32'(7'b1111001));
    $display("wrap-cycle load: d0 seg_n=%b", seg_n);

    // Decimal point on digit 2 only, blanked for the first B cycles of the digit.
    idle_until(20);
    cycle(1'b1, 32'h00000000, 8'b0000_0100);
    idle_until(0);
    idle_until(16);
    check("dp_blank", 32'(dp_n), 32'd1);
    idle_until(16 + B);
    check("dp_on", 32'(dp_n), 32'd0);
    idle_until(24 + B);
    check("dp_off_d3", 32'(dp_n), 32'd1);
    $display("dp mask: digit2 dp checked");

    // Random loads against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(39) == 0) cycle(1'b1, $urandom, 8'($urandom));
      else cycle(1'b0, 32'd0, 8'd0);
    end
    $display("random run: 1500 cycles checked");

    // Reset mid-scan at cuenta=5 with a pending load.
    idle_until(45);
    cycle(1'b1, 32'hDEADBEEF, 8'hFF);
    reset_n = 1'b0;
    #1;
    check("rst_cuenta", 32'(cuenta), 32'd0);
    check("rst_seg", 32'(seg_n), 32'(7'h7F));
    check("rst_dp", 32'(dp_n), 32'd1);
    check("rst_ftick", 32'(frame_tick), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    repeat (140) cycle(1'b0, 32'd0, 8'd0);
    $display("mid-scan reset: pending discarded, 140 cycles checked");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
